// File: rtl/set_pkg.sv
// Shared defaults and types for the set_ramp setpoint ramp generator.
package set_pkg;

   localparam int unsigned WIDTH_SET_DEF = 16;
   localparam int unsigned DW            = 2 * WIDTH_SET_DEF;

   typedef logic signed [DW-1:0] set_word_t;

   typedef enum logic [1:0] {
      StIdle,
      StRamp,
      StWaitAck
   } state_e;

endpackage

// File: rtl/set_ramp_ch.sv
// One setpoint channel: computes the next ramped value toward target without overshoot or wrap.
module set_ramp_ch #(
   parameter int unsigned WIDTH_SET = 16
) (
   input  logic signed [2*WIDTH_SET-1:0] cur,
   input  logic signed [2*WIDTH_SET-1:0] target,
   input  logic        [WIDTH_SET-1:0]   step,
   output logic signed [2*WIDTH_SET-1:0] nxt,
   output logic                          at_target
);

   localparam int unsigned DataW = 2 * WIDTH_SET;

   logic signed [DataW:0]   diff;
   logic        [DataW:0]   mag;
   logic        [DataW:0]   step_ext;
   logic        [DataW-1:0] step_w;

   always_comb begin
      // One extra bit so target - cur never overflows.
      diff      = {target[DataW-1], target} - {cur[DataW-1], cur};
      mag       = diff[DataW] ? -diff : diff;
      step_ext  = {{(DataW + 1 - WIDTH_SET){1'b0}}, step};
      step_w    = {{WIDTH_SET{1'b0}}, step};
      at_target = (diff == '0);
      if ((step == '0) || (mag <= step_ext)) begin
         nxt = target;
      end else if (diff[DataW]) begin
         nxt = cur - step_w;
      end else begin
         nxt = cur + step_w;
      end
   end

endmodule

// File: rtl/set_ramp.sv
// Three-channel setpoint ramp with tick prescaler and valid/ready output handshake.
// Optional target clamping and sticky lim_hit flag when SET_RAMP_LIMIT_EN is defined.
module set_ramp
   import set_pkg::*;
#(
   parameter int unsigned                WIDTH_SET = WIDTH_SET_DEF,
   parameter int unsigned                DIV_W     = 16,
   parameter logic signed [2*WIDTH_SET-1:0] LIM_MIN = {1'b1, {(2*WIDTH_SET-1){1'b0}}},
   parameter logic signed [2*WIDTH_SET-1:0] LIM_MAX = {1'b0, {(2*WIDTH_SET-1){1'b1}}}
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [2*WIDTH_SET-1:0] x_set,
   input  logic signed [2*WIDTH_SET-1:0] i_set,
   input  logic signed [2*WIDTH_SET-1:0] fi_set,
   input  logic                          set_load,
   input  logic                          enable,
   input  logic        [WIDTH_SET-1:0]   step,
   input  logic        [DIV_W-1:0]       div,
   output logic signed [2*WIDTH_SET-1:0] x_out,
   output logic signed [2*WIDTH_SET-1:0] i_out,
   output logic signed [2*WIDTH_SET-1:0] fi_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
`ifdef SET_RAMP_LIMIT_EN
   output logic                          done,
   output logic                          lim_hit
`else
   output logic                          done
`endif
);

   localparam int unsigned DataW = 2 * WIDTH_SET;
   localparam int          NumCh = 3;

   typedef logic signed [DataW-1:0] word_t;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic              en_q;
   logic              done_q, done_d;
   logic              pend_v_q, pend_v_d;
   word_t             cur_q[NumCh], cur_d[NumCh];
   word_t             tgt_q[NumCh], tgt_d[NumCh];
   word_t             pend_q[NumCh], pend_d[NumCh];
   word_t             set_in[NumCh], set_lat[NumCh], nxt[NumCh], hs_tgt[NumCh];
   logic [NumCh-1:0]  at_tgt;
   logic              all_eq;

   assign set_in[0] = x_set;
   assign set_in[1] = i_set;
   assign set_in[2] = fi_set;

`ifdef SET_RAMP_LIMIT_EN
   logic [NumCh-1:0] clip;
   logic             lim_hit_q, lim_hit_d;

   always_comb begin
      clip = '0;
      for (int c = 0; c < NumCh; c++) begin
         set_lat[c] = set_in[c];
         if (set_in[c] < LIM_MIN) begin
            set_lat[c] = LIM_MIN;
            clip[c]    = 1'b1;
         end else if (set_in[c] > LIM_MAX) begin
            set_lat[c] = LIM_MAX;
            clip[c]    = 1'b1;
         end
      end
      lim_hit_d = lim_hit_q | (set_load & (|clip));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lim_hit_q <= 1'b0;
      else      lim_hit_q <= lim_hit_d;
   end

   assign lim_hit = lim_hit_q;
`else
   logic unused_lim;
   assign unused_lim = ^{LIM_MIN, LIM_MAX};

   always_comb begin
      for (int c = 0; c < NumCh; c++) set_lat[c] = set_in[c];
   end
`endif

   for (genvar g = 0; g < NumCh; g++) begin : g_ch
      set_ramp_ch #(
         .WIDTH_SET(WIDTH_SET)
      ) u_ch (
         .cur      (cur_q[g]),
         .target   (tgt_q[g]),
         .step     (step),
         .nxt      (nxt[g]),
         .at_target(at_tgt[g])
      );
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_d    = cur_q;
      tgt_d    = tgt_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      done_d   = 1'b0;
      hs_tgt   = tgt_q;
      all_eq   = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (set_load) tgt_d = set_lat;
            if ((set_load && enable) || (enable && !en_q && !(&at_tgt))) begin
               state_d = StRamp;
               cnt_d   = '0;
            end
         end
         StRamp: begin
            // Retarget on the fly; prescaler phase is kept.
            if (set_load) tgt_d = set_lat;
            if (!enable) begin
               state_d = StIdle;
            end else if (cnt_q == div) begin
               cur_d   = nxt;
               cnt_d   = '0;
               state_d = StWaitAck;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWaitAck: begin
            if (set_load) begin
               pend_d   = set_lat;
               pend_v_d = 1'b1;
            end
            if (out_ready) begin
               // A load on the handshake cycle beats an older pending one.
               if (set_load)      hs_tgt = set_lat;
               else if (pend_v_q) hs_tgt = pend_q;
               tgt_d    = hs_tgt;
               pend_v_d = 1'b0;
               for (int c = 0; c < NumCh; c++) all_eq = all_eq & (cur_q[c] == hs_tgt[c]);
               if (all_eq) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else if (enable) begin
                  state_d = StRamp;
                  cnt_d   = '0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         pend_v_q <= 1'b0;
         for (int c = 0; c < NumCh; c++) begin
            cur_q[c]  <= '0;
            tgt_q[c]  <= '0;
            pend_q[c] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         en_q     <= enable;
         done_q   <= done_d;
         pend_v_q <= pend_v_d;
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         pend_q   <= pend_d;
      end
   end

   assign x_out     = cur_q[0];
   assign i_out     = cur_q[1];
   assign fi_out    = cur_q[2];
   assign out_valid = (state_q == StWaitAck);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

endmodule

// File: tb/tb_set_ramp.sv
// Directed self-checking bench for set_ramp; SET_RAMP_LIMIT_EN selects the clamp scenario.
module tb_set_ramp;
   import set_pkg::*;

`ifdef SET_RAMP_LIMIT_EN
   localparam logic signed [31:0] LimMax = 32'sd1000;
`else
   localparam logic signed [31:0] LimMax = 32'sh7FFF_FFFF;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   set_word_t   x_set, i_set, fi_set;
   logic        set_load, enable, out_ready;
   logic [15:0] step, div;
   set_word_t   x_out, i_out, fi_out;
   logic        out_valid, busy, done;
`ifdef SET_RAMP_LIMIT_EN
   logic        lim_hit;
`endif

   int errors = 0;
   int checks = 0;
   int n;
   logic stable;

   always #5 clk = ~clk;

   set_ramp #(
      .WIDTH_SET(16),
      .DIV_W    (16),
      .LIM_MIN  (32'sh8000_0000),
      .LIM_MAX  (LimMax)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .x_set    (x_set),
      .i_set    (i_set),
      .fi_set   (fi_set),
      .set_load (set_load),
      .enable   (enable),
      .step     (step),
      .div      (div),
      .x_out    (x_out),
      .i_out    (i_out),
      .fi_out   (fi_out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy),
`ifdef SET_RAMP_LIMIT_EN
      .done     (done),
      .lim_hit  (lim_hit)
`else
      .done     (done)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] x, input logic [31:0] i, input logic [31:0] fi);
      x_set    = x;
      i_set    = i;
      fi_set   = fi;
      set_load = 1'b1;
      step_clk();
      set_load = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int cnt);
      cnt = 0;
      do begin
         step_clk();
         cnt++;
      end while (!out_valid && cnt < 200);
      chk(tag, out_valid, 1'b1);
   endtask

   initial begin
      set_load = 0; enable = 0; out_ready = 0; step = 0; div = 0;
      x_set = 0; i_set = 0; fi_set = 0;
      #12;
      chk("rst_x", x_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef SET_RAMP_LIMIT_EN
      chk("rst_lim", lim_hit, 0);
`endif
      rst = 1'b1;
      step_clk();
      step_clk();

      // x up 0->1000, fi down 0->-300, step 100, tick every 4 cycles
      enable = 1; out_ready = 1; step = 16'd100; div = 16'd3;
      load(32'd1000, 32'd0, -32'sd300);
      for (int k = 1; k <= 10; k++) begin
         wait_valid("ramp_to", n);
         chk("ramp_gap", n, (k == 1) ? 4 : 5);
         chk("ramp_x", x_out, 100 * k);
         chk("ramp_fi", fi_out, -(100 * ((k < 3) ? k : 3)));
         chk("ramp_done_early", done, 0);
      end
      step_clk();
      chk("ramp_done", done, 1);
      chk("ramp_idle", busy, 0);
      chk("ramp_final_x", x_out, 1000);
      step_clk();
      chk("ramp_done_pulse", done, 0);

      // step 0 jumps straight to target
      step = 16'd0;
      load(32'd1000, -32'sd5000, -32'sd300);
      wait_valid("jump_to", n);
      chk("jump_gap", n, 4);
      chk("jump_i", i_out, -32'sd5000);
      chk("jump_x", x_out, 1000);
      step_clk();
      chk("jump_done", done, 1);

      // stall in WAIT_ACK, pending load equal to current output ends the ramp
      step = 16'd100; out_ready = 0;
      load(32'd700, -32'sd5000, -32'sd300);
      wait_valid("stall_to", n);
      chk("stall_x", x_out, 900);
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c == 10) load(32'd900, -32'sd5000, -32'sd300);
         else step_clk();
         stable = stable & (out_valid === 1'b1) & (x_out === 32'sd900);
      end
      chk("stall_stable", stable, 1);
      out_ready = 1;
      step_clk();
      chk("pend_done", done, 1);
      chk("pend_x", x_out, 900);
      chk("pend_idle", busy, 0);

      // retarget coincident with handshake at x=500
      step = 16'd0;
      load(32'd0, -32'sd5000, -32'sd300);
      wait_valid("zero_to", n);
      chk("zero_x", x_out, 0);
      step_clk();
      step = 16'd100;
      load(32'd1000, -32'sd5000, -32'sd300);
      for (int k = 1; k <= 5; k++) begin
         wait_valid("re_to", n);
         chk("re_x", x_out, 100 * k);
      end
      x_set = 32'd300;
      set_load = 1'b1;
      step_clk();
      set_load = 1'b0;
      chk("re_busy", busy, 1);
      chk("re_nodone", done, 0);
      wait_valid("re_to2", n);
      chk("re_x400", x_out, 400);
      wait_valid("re_to3", n);
      chk("re_x300", x_out, 300);
      step_clk();
      chk("re_done", done, 1);

`ifdef SET_RAMP_LIMIT_EN
      step = 16'd0;
      load(32'd5000, -32'sd5000, -32'sd300);
      wait_valid("lim_to", n);
      chk("lim_x", x_out, 1000);
      chk("lim_hit", lim_hit, 1);
      step_clk();
      chk("lim_done", done, 1);
`else
      step = 16'd0;
      load(32'h7FFF_FF00, -32'sd5000, -32'sd300);
      wait_valid("top_to", n);
      chk("top_base", x_out, 32'h7FFF_FF00);
      step_clk();
      step = 16'h0200;
      load(32'h7FFF_FFFF, -32'sd5000, -32'sd300);
      wait_valid("wrap_to", n);
      chk("wrap_x", x_out, 32'h7FFF_FFFF);
      step_clk();
      chk("wrap_done", done, 1);
      chk("wrap_hold", x_out, 32'h7FFF_FFFF);
`endif

      // asynchronous reset while out_valid is high
      step = 16'h0100; out_ready = 0;
      load(32'd0, -32'sd5000, -32'sd300);
      wait_valid("ar_to", n);
      #2 rst = 1'b0;
      #1;
      chk("ar_x", x_out, 0);
      chk("ar_i", i_out, 0);
      chk("ar_fi", fi_out, 0);
      chk("ar_valid", out_valid, 0);
      chk("ar_busy", busy, 0);
`ifdef SET_RAMP_LIMIT_EN
      chk("ar_lim", lim_hit, 0);
`endif
      step_clk();
      rst = 1'b1;
      out_ready = 1;
      step_clk();
      step_clk();
      chk("ar_idle", busy, 0);
      chk("ar_nodone", done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
